mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit. Sits beside the combinational ALU in the execute stage of the multi-cycle CPU.
- Takes operand pairs through a valid/ready handshake and runs the operation over multiple cycles. Returns a 32-bit result through a valid/ready handshake to writeback.
- Op encoding follows RV32M funct3, so the decoder can pass instruction bits straight through.

Parameters:
- WIDTH, 32: operand/result width. Only 32 is supported; the counter width is derived as clog2(WIDTH)+1.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operand pair and op are valid
- in_ready  out  1  unit can accept an op
- op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- dataa  in  WIDTH  rs1 operand
- datab  in  WIDTH  rs2 operand
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  operation result
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, result=0, busy=0.
  - All internal registers are 0.
  - Asserting reset mid-operation aborts it immediately; no result is produced.
- States:
  - IDLE: in_ready=1.
  - CALC: 32 iterations.
  - DONE: out_valid=1, result held stable.
- Handshake:
  - An op is accepted on a rising edge with in_valid && in_ready. op, dataa and datab are latched at acceptance; later input changes are ignored.
  - A result transfers on an edge with out_valid && out_ready; the unit then returns to IDLE.
  - in_ready=0 in DONE, so there is no accept in the same cycle as the result transfer. The next accept is possible one cycle after the transfer.
- Transitions:
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept when a special case applies.
  - CALC -> DONE when the iteration counter reaches 32.
  - DONE -> IDLE on result transfer.
- Latency:
  - Normal op: out_valid rises 33 edges after the accept edge (32 CALC cycles plus the finalise edge).
  - Special case: out_valid rises 1 edge after the accept edge.
- Multiply:
  - Operands are sign- or zero-extended to 33 bits per op: MULH both signed, MULHSU a signed/b unsigned, MULHU and MUL unsigned.
  - Radix-2 shift-add on the 33-bit magnitudes of the extended operands; the product sign is applied at finalise.
  - MUL returns the low 32 bits of the 64-bit product. MULH, MULHSU and MULHU return the high 32 bits.
  - The low 32 bits of MUL are identical for signed and unsigned operands.
- Divide:
  - Restoring algorithm, one quotient bit per cycle, on the magnitudes |a| and |b| for signed ops and on raw values for unsigned ops.
  - Finalise, signed ops:
    - quotient is negated if sign(a) XOR sign(b);
    - remainder takes the sign of a.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (decided at accept, no iteration):
  - datab==0, divide ops: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dataa.
  - DIV with dataa=0x80000000 and datab=0xFFFFFFFF -> 0x80000000; the matching REM -> 0.
  - Multiply ops have no special case; an operand of zero still takes 33 cycles.
- No flush input. The pipeline must not issue a new op while busy=1.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD): accept, then out_valid exactly 33 edges later, result 0xFFFFFFEB. With out_ready held 0 for 5 cycles, the result stays stable; transfer occurs on the first out_ready=1 edge.
- High products, a=0x80000000, b=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHU -> 0x7FFFFFFF
  - MULHSU -> 0x80000000
- Signed divide, a=-7 (0xFFFFFFF9), b=2:
  - DIV -> 0xFFFFFFFD
  - REM -> 0xFFFFFFFF
  - DIVU -> 0x7FFFFFFC
  - REMU -> 0x00000001
- Special cases each give out_valid 1 edge after accept:
  - DIVU 5/0 -> 0xFFFFFFFF
  - REM 5/0 -> 0x00000005
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000
  - REM of the same pair -> 0
- Reset mid-op: assert reset asynchronously at CALC iteration 10. Outputs immediately return to in_ready=1, out_valid=0, busy=0. A following MULHU 0xFFFFFFFF x 0xFFFFFFFF then yields 0xFFFFFFFE.
- Back-to-back with in_valid held high: in_ready=0 throughout CALC/DONE; the second op is accepted exactly one cycle after the first result transfers. Operand changes while busy do not affect the first result.

Source files
------------

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
//
// Iterative RV32M multiply/divide unit for the execute stage of the multi-cycle
// CPU. An operation is taken in through a valid/ready handshake. It is run one
// bit per cycle: shift-add for multiplies and restoring division for divides.
// The 32-bit result is handed to writeback through a second valid/ready
// handshake.
//
// Ports
//   clock      in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   in_valid   in   1      op/dataa/datab are valid
//   in_ready   out  1      unit can accept an op (registered, high in IDLE)
//   op         in   3      RV32M funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   dataa      in   WIDTH  rs1 operand
//   datab      in   WIDTH  rs2 operand
//   out_valid  out  1      result is valid (registered, high in DONE)
//   out_ready  in   1      consumer accepts the result
//   result     out  WIDTH  operation result, held stable while out_valid
//   busy       out  1      high while in CALC or DONE
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_operand;
  logic [CW-1:0]      r_count;
  logic               r_neg_lo;
  logic               r_neg_rem;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   r_result;

  // Accept-time decode
  logic               w_is_div;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_result;

  // Iteration datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_rem;

  // Finalise datapath
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_signed;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

  // Operand decode at accept. A sign-extended 33-bit operand always has a
  // magnitude that fits in WIDTH bits (|-2^31| = 2^31), so the iterative
  // datapath only ever works on WIDTH-bit unsigned magnitudes and the sign
  // is reapplied at finalise. For plain MUL the operands are treated as
  // unsigned, which gives the same low word as a signed multiply.
  always_comb begin
    w_is_div   = op[2];
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (op)
      OP_MULH:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      OP_MULHSU: begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
      OP_DIV:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      OP_REM:    begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      default:   begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
    endcase
    w_a_neg = w_a_signed & dataa[WIDTH-1];
    w_b_neg = w_b_signed & datab[WIDTH-1];
    w_a_mag = w_a_neg ? (~dataa + 1'b1) : dataa;
    w_b_mag = w_b_neg ? (~datab + 1'b1) : datab;
  end

  // Division corner cases resolved at accept without iterating: divide by
  // zero, and the single signed overflow (most negative / -1).
  always_comb begin
    w_div_zero       = w_is_div & (datab == '0);
    w_div_ovf        = w_is_div & ~op[0] & (dataa == MIN_NEG) & (datab == ALL_ONE);
    w_special        = w_div_zero | w_div_ovf;
    w_special_result = '0;
    if (w_div_zero) begin
      w_special_result = op[1] ? dataa : ALL_ONE;
    end else if (w_div_ovf) begin
      w_special_result = op[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step. Multiply: {r_hi, r_lo} is the partial product with
  // the multiplier shifting out of r_lo. Divide: r_hi is the partial
  // remainder, r_lo shifts the dividend out at the top and the quotient in
  // at the bottom. The remainder is always below the divisor, so the trial
  // difference fits in WIDTH bits whenever it is kept.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ok    = (w_div_shift >= {1'b0, r_operand});
    w_div_rem   = WIDTH'(w_div_shift - {1'b0, r_operand});
  end

  // Finalise: reapply signs and select the word the op returns. The negate
  // flags are only ever set for signed ops.
  always_comb begin
    w_prod        = {r_hi, r_lo};
    w_prod_signed = r_neg_lo ? (~w_prod + 1'b1) : w_prod;
    w_quot        = r_neg_lo ? (~r_lo + 1'b1) : r_lo;
    w_rem         = r_neg_rem ? (~r_hi + 1'b1) : r_hi;
    w_final       = '0;
    case (r_op)
      OP_MUL:    w_final = w_prod_signed[WIDTH-1:0];
      OP_MULH:   w_final = w_prod_signed[2*WIDTH-1:WIDTH];
      OP_MULHSU: w_final = w_prod_signed[2*WIDTH-1:WIDTH];
      OP_MULHU:  w_final = w_prod_signed[2*WIDTH-1:WIDTH];
      OP_DIV:    w_final = w_quot;
      OP_DIVU:   w_final = w_quot;
      OP_REM:    w_final = w_rem;
      OP_REMU:   w_final = w_rem;
      default:   w_final = '0;
    endcase
  end

  // Control FSM with registered handshake outputs.
  // CALC runs WIDTH iteration cycles and then spends one more cycle on the
  // finalise edge, so out_valid rises WIDTH+1 edges after accept. A special
  // case loads its result at accept and enters DONE with out_valid still
  // low; out_valid is raised on the next edge, one edge after accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_operand   <= '0;
      r_count     <= '0;
      r_neg_lo    <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op       <= op;
            r_hi       <= '0;
            r_lo       <= w_is_div ? w_a_mag : w_b_mag;
            r_operand  <= w_is_div ? w_b_mag : w_a_mag;
            r_count    <= '0;
            r_neg_lo   <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_result <= w_special_result;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (r_count == ITERS) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_count <= r_count + CW'(1);
            if (r_op[2]) begin
              r_hi <= w_div_ok ? w_div_rem : w_div_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
            end else begin
              r_hi <= w_mul_sum[WIDTH:1];
              r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
          end
        end

        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
//
// Directed bench for mdu_iter. A table of {op, operands, expected result,
// expected latency} vectors is pushed through the unit one at a time. It is
// followed by hand-written sequences for a stalled consumer, a reset in the
// middle of an operation, and back-to-back issue with in_valid held high.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int NUM_VECTORS = 18;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    int          latency;
  } vector_t;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  op;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        busy;

  int          testsRun;
  int          testsFailed;
  bit          readySeen;
  vector_t     vectors [NUM_VECTORS];

  mdu_iter #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .op        (op),
    .dataa     (dataA),
    .datab     (dataB),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .busy      (busy)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and log a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present an op at the falling edge and let the next rising edge accept it;
  // returns 1 time unit after the accept edge
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, input bit holdValid);
    @(negedge clock);
    op      = opIn;
    dataA   = a;
    dataB   = b;
    inValid = 1'b1;
    checkOutput("accept in_ready", {31'b0, inReady}, 32'd1);
    @(posedge clock);
    #1;
    if (!holdValid) inValid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, then check latency and
  // result. A timeout is counted as a failure and the DUT is reset.
  task automatic waitResult(input string name, input int expLatency,
                            input logic [31:0] expResult);
    int lat;
    lat       = 0;
    readySeen = 1'b0;
    do begin
      @(posedge clock);
      #1;
      lat++;
      if (inReady) readySeen = 1'b1;
    end while (!outValid && lat < 60);
    checkOutput({name, " latency"}, 32'(lat), 32'(expLatency));
    checkOutput({name, " result"}, result, expResult);
    if (!outValid) begin
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
    end
  endtask

  // Accept the result with out_ready for one edge
  task automatic transferResult(input string name);
    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    checkOutput({name, " out_valid after transfer"}, {31'b0, outValid}, 32'd0);
  endtask

  initial begin
    bit unstable;

    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    op       = 3'b000;
    dataA    = '0;
    dataB    = '0;
    testsRun    = 0;
    testsFailed = 0;

    vectors[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vectors[1]  = '{OP_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vectors[2]  = '{OP_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 33};
    vectors[3]  = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vectors[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vectors[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vectors[6]  = '{OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33};
    vectors[7]  = '{OP_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33};
    vectors[8]  = '{OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1};
    vectors[9]  = '{OP_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1};
    vectors[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vectors[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vectors[12] = '{OP_MUL,    32'h12345678, 32'h00000000, 32'h00000000, 33};
    vectors[13] = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vectors[14] = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vectors[15] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        33};
    vectors[16] = '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vectors[17] = '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33};

    // Reset state
    #1;
    checkOutput("reset in_ready",  {31'b0, inReady},  32'd1);
    checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset busy",      {31'b0, busy},     32'd0);
    checkOutput("reset result",    result,            32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NUM_VECTORS; i++) begin
      applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, 1'b0);
      waitResult($sformatf("vec%0d", i), vectors[i].latency, vectors[i].expected);
      transferResult($sformatf("vec%0d", i));
    end

    // Consumer stalls for 5 cycles: result must hold until out_ready
    applyStimulus(OP_MUL, 32'h00000007, 32'hFFFFFFFD, 1'b0);
    waitResult("stall", 33, 32'hFFFFFFEB);
    unstable = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
      if (!outValid || result !== 32'hFFFFFFEB) unstable = 1'b1;
    end
    checkOutput("stall result held", {31'b0, unstable}, 32'd0);
    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    checkOutput("stall out_valid after transfer", {31'b0, outValid}, 32'd0);
    checkOutput("stall in_ready after transfer",  {31'b0, inReady},  32'd1);

    // Asynchronous reset during CALC iteration 10
    applyStimulus(OP_MUL, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset in_ready",  {31'b0, inReady},  32'd1);
    checkOutput("midreset out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("midreset busy",      {31'b0, busy},     32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitResult("post-reset mulhu", 33, 32'hFFFFFFFE);
    transferResult("post-reset mulhu");

    // Back-to-back issue with in_valid held high; operands change while busy
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1);
    op    = OP_MUL;
    dataA = 32'd3;
    dataB = 32'd5;
    checkOutput("b2b busy after accept", {31'b0, busy}, 32'd1);
    waitResult("b2b first", 33, 32'd14);
    checkOutput("b2b in_ready low while busy", {31'b0, readySeen}, 32'd0);
    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    checkOutput("b2b transfer out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("b2b transfer in_ready",  {31'b0, inReady},  32'd1);
    checkOutput("b2b transfer busy",      {31'b0, busy},     32'd0);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    checkOutput("b2b second accepted busy",     {31'b0, busy},    32'd1);
    checkOutput("b2b second accepted in_ready", {31'b0, inReady}, 32'd0);
    waitResult("b2b second", 33, 32'd15);
    transferResult("b2b second");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
